// File: rtl/counter_sched.sv
// Round-robin scheduler that time-shares one external loadable up-counter among
// NUM_REQ requesters, running each job to its target or aborting it on timeout.
module counter_sched #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   target,
  input  logic [NUM_REQ*WIDTH-1:0]   step,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic                       err,
  output logic [WIDTH-1:0]           result,
  output logic                       busy,
  output logic                       cnt_reset,
  output logic                       cnt_enable,
  output logic [WIDTH-1:0]           cnt_count_in,
  input  logic [WIDTH-1:0]           cnt_count_out
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int TMR_W = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, rr_ptr, pick_idx, cand_idx;
  logic               pick_vld;
  logic [WIDTH-1:0]   tgt_q, step_q;
  logic [TMR_W-1:0]   timer;
  logic               err_q;
  logic               hit, tmo;

  assign hit = (cnt_count_out >= tgt_q);
  assign tmo = (timer == TMR_W'(TIMEOUT - 1));

  // Scan from farthest to nearest offset so the first requester after rr_ptr wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (req[cand_idx]) begin
        pick_vld = 1'b1;
        pick_idx = cand_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (pick_vld) state_nxt = CLEAR;
      CLEAR: state_nxt = RUN;
      RUN: begin
        if (hit || tmo)   state_nxt = DONE;
        else if (!req[idx]) state_nxt = IDLE;
      end
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy         = (state != IDLE);
    cnt_reset    = !reset || (state == CLEAR);
    cnt_enable   = (state == RUN) && (cnt_count_out < tgt_q);
    cnt_count_in = (state == RUN) ? step_q : '0;
    done         = (state == DONE) ? gnt : '0;
    err          = (state == DONE) && err_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt    <= '0;
      idx    <= '0;
      rr_ptr <= IDX_W'(NUM_REQ - 1);
      timer  <= '0;
      err_q  <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            gnt <= NUM_REQ'(1) << pick_idx;
            idx <= pick_idx;
          end
        end
        CLEAR: timer <= '0;
        RUN: begin
          timer <= timer + TMR_W'(1);
          if (hit) begin
            result <= cnt_count_out;
            err_q  <= 1'b0;
          end else if (tmo) begin
            result <= cnt_count_out;
            err_q  <= 1'b1;
          end else if (!req[idx]) begin
            gnt <= '0;
          end
        end
        DONE: begin
          gnt    <= '0;
          rr_ptr <= idx;
        end
        default: gnt <= '0;
      endcase
    end
  end

  // Job parameters are snapshotted at grant so input changes mid-job are ignored.
  always_ff @(posedge clk) begin
    if (state == IDLE && pick_vld) begin
      tgt_q  <= target[pick_idx*WIDTH +: WIDTH];
      step_q <= step[pick_idx*WIDTH +: WIDTH];
    end
  end

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: models the shared counter and scores every done pulse
// against a queue of expected (requester, result, err) tuples.
module tb_counter_sched;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 4;
  localparam int TIMEOUT = 32;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] target, step;
  logic [NUM_REQ-1:0]       gnt, done;
  logic                     err, busy, cnt_reset, cnt_enable;
  logic [WIDTH-1:0]         result, cnt_count_in, cnt_count_out;
  logic [WIDTH-1:0]         cnt_q = '0;

  counter_sched #(.NUM_REQ(NUM_REQ), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .target(target), .step(step),
    .gnt(gnt), .done(done), .err(err), .result(result), .busy(busy),
    .cnt_reset(cnt_reset), .cnt_enable(cnt_enable), .cnt_count_in(cnt_count_in),
    .cnt_count_out(cnt_count_out)
  );

  always #5 clk = ~clk;

  // Shared counter: clear has priority over enable, addition wraps mod 2^WIDTH.
  always @(posedge clk) begin
    if (cnt_reset)       cnt_q <= '0;
    else if (cnt_enable) cnt_q <= cnt_q + cnt_count_in;
  end
  assign cnt_count_out = cnt_q;

  typedef struct packed {
    logic [1:0] idx;
    logic [3:0] res;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expire(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", name, $time);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (err && done == '0) check("err_without_done", 1, 0);
      if (done != '0) begin
        if (sb.size() == 0) check("unexpected_done", int'(done), 0);
        else begin
          mon_e = sb.pop_front();
          check("done_idx", int'(done), 1 << mon_e.idx);
          check("result", int'(result), int'(mon_e.res));
          check("err", int'(err), int'(mon_e.err));
        end
      end
    end
  end

  task automatic expect_job(input int i, input int res, input int e);
    exp_t x;
    x.idx = 2'(i);
    x.res = 4'(res);
    x.err = 1'(e);
    sb.push_back(x);
  endtask

  task automatic set_job(input int i, input int t, input int s);
    target[i*WIDTH +: WIDTH] = 4'(t);
    step[i*WIDTH +: WIDTH]   = 4'(s);
  endtask

  task automatic wait_done(input int i);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (done[i]) break;
    end
    if (k == 200) expire("wait_done");
  endtask

  task automatic wait_gnt(input int i);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (gnt[i]) break;
    end
    if (k == 200) expire("wait_gnt");
  endtask

  task automatic run_job(input int i, input int t, input int s, input int res, input int e);
    expect_job(i, res, e);
    set_job(i, t, s);
    req[i] = 1'b1;
    wait_done(i);
    req[i] = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"}, int'(gnt), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_result"}, int'(result), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_cnt_reset"}, int'(cnt_reset), 1);
    check({tag, "_cnt_enable"}, int'(cnt_enable), 0);
    check({tag, "_cnt_count_in"}, int'(cnt_count_in), 0);
  endtask

  initial begin
    int ndone;
    int lat;
    reset  = 1'b0;
    req    = '0;
    target = '0;
    step   = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    @(negedge clk);
    check("idle_cnt_reset", int'(cnt_reset), 0);
    check("idle_busy", int'(busy), 0);

    // All four request together: grants rotate 0,1,2,3 then back to 0.
    for (int i = 0; i < NUM_REQ; i++) set_job(i, 1, 1);
    expect_job(0, 1, 0);
    expect_job(1, 1, 0);
    expect_job(2, 1, 0);
    expect_job(3, 1, 0);
    expect_job(0, 1, 0);
    req   = 4'b1111;
    ndone = 0;
    for (int k = 0; k < 400 && ndone < 5; k++) begin
      @(negedge clk);
      check("gnt_onehot0", int'($onehot0(gnt)), 1);
      if (done != '0) ndone++;
    end
    req = '0;
    if (ndone < 5) expire("rr_five_jobs");

    // Plain jobs: exact hit, and an overshooting step that freezes at 6.
    run_job(0, 3, 1, 3, 0);
    run_job(0, 5, 2, 6, 0);

    // Wrap past target: 0,2,..,14,0,.. never >= 15; timer expires on count 62 mod 16.
    run_job(2, 15, 2, 14, 1);

    // Zero target: grant (CLEAR) -> RUN -> DONE on consecutive cycles.
    expect_job(1, 0, 0);
    set_job(1, 0, 3);
    req[1] = 1'b1;
    wait_gnt(1);
    lat = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      lat++;
      if (done[1]) break;
    end
    req[1] = 1'b0;
    check("lat_target0", lat, 2);

    // Zero step never advances the counter.
    run_job(1, 5, 0, 0, 1);

    // Requester withdraws mid-RUN: job abandoned silently.
    set_job(0, 15, 2);
    req[0] = 1'b1;
    wait_gnt(0);
    repeat (5) @(negedge clk);
    check("abort_busy_before", int'(busy), 1);
    req[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_gnt", int'(gnt), 0);
    check("abort_busy", int'(busy), 0);
    run_job(1, 2, 1, 2, 0);

    // Asynchronous reset mid-RUN, asserted away from any clock edge.
    set_job(2, 15, 2);
    req[2] = 1'b1;
    wait_gnt(2);
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_outputs("midrst");
    req[2] = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_job(3, 4, 2, 4, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
